// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths for the SRAM port arbiter.
//   state_e : arbiter FSM states
//   owner_e : requester identity (CPU = 0, DMA = 1)
package sram_arb_pkg;
  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, purely combinational.
//   req[1:0]    in  : request vector, bit 0 = CPU, bit 1 = DMA
//   last        in  : previous grantee id
//   grant_valid out : any request present
//   grant_id    out : winner id (a tie goes to the one that was not last)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id    = &req ? ~last : req[1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM between CPU and DMA requesters.
//   Clk, Reset_n                     : clock, async active-low reset
//   cpu_* / dma_*                    : req/we/addr/wdata in, rdata/done out
//   sram_addr, sram_wdata            : registered SRAM address and write data
//   sram_data_oe                     : FPGA drives the SRAM data bus
//   sram_rdata                       : SRAM data bus input
//   Mem_CE/UB/LB/OE/WE               : active-low SRAM strobes
//   busy, owner                      : not idle; current or last grantee
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = SRAM_ADDR_W,
  parameter int unsigned DATA_W        = SRAM_DATA_W,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy,
  output logic              owner
);
  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_e            state_q;
  owner_e            owner_q, last_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, dma_rdata_q;
  logic              we_d, grant_valid, grant_id, in_access;

  rr_pick2 u_pick (
    .req        ({dma_req, cpu_req}),
    .last       (last_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign addr_d  = grant_id ? dma_addr  : cpu_addr;
  assign wdata_d = grant_id ? dma_wdata : cpu_wdata;
  assign we_d    = grant_id ? dma_we    : cpu_we;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DMA;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_valid) begin
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          we_q    <= we_d;
          owner_q <= owner_e'(grant_id);
          last_q  <= owner_e'(grant_id);
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: if (cnt_q == CNT_LAST) begin
          // read data is sampled on the edge that ends the strobe window
          if (!we_q && owner_q == OWN_CPU) cpu_rdata_q <= sram_rdata;
          if (!we_q && owner_q == OWN_DMA) dma_rdata_q <= sram_rdata;
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // strobes depend only on registered state, so they cannot glitch within a state
  assign in_access    = state_q == ACCESS;
  assign Mem_CE       = ~in_access;
  assign Mem_UB       = ~in_access;
  assign Mem_LB       = ~in_access;
  assign Mem_OE       = ~(in_access & ~we_q);
  assign Mem_WE       = ~(in_access & we_q);
  assign sram_data_oe = in_access & we_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign cpu_done     = state_q == DONE && owner_q == OWN_CPU;
  assign dma_done     = state_q == DONE && owner_q == OWN_DMA;
  assign busy         = state_q != IDLE;
  assign owner        = owner_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter.
module tb_sram_port_arbiter;
  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [19:0] cpu_addr = 0, dma_addr = 0, sram_addr;
  logic [15:0] cpu_wdata = 0, dma_wdata = 0, cpu_rdata, dma_rdata, sram_wdata, sram_rdata;
  logic        cpu_done, dma_done, sram_data_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy, owner;
  logic        b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
  logic [19:0] b_cpu_addr = 0, b_dma_addr = 0, b_sram_addr;
  logic [15:0] b_cpu_wdata = 0, b_dma_wdata = 0, b_cpu_rdata, b_dma_rdata, b_sram_wdata;
  logic [15:0] b_sram_rdata = 16'hCAFE;
  logic        b_cpu_done, b_dma_done, b_data_oe, b_ce, b_ub, b_lb, b_oe, b_we, b_busy, b_owner;
  logic [19:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  int          wr_cnt = 0;
  int          errors = 0, checks = 0;

  always #5 Clk = ~Clk;

  assign sram_rdata = sram_addr == 20'h00123 ? 16'hBEEF :
                      sram_addr == 20'h00010 ? 16'h1111 :
                      sram_addr == 20'h00020 ? 16'h2222 : 16'h0000;

  always @(posedge Clk) if (!Mem_CE && !Mem_WE) begin
    wr_addr <= sram_addr;
    wr_data <= sram_wdata;
    wr_cnt  <= wr_cnt + 1;
  end

  sram_port_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
    .sram_rdata(sram_rdata),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .busy(busy), .owner(owner)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_done(b_dma_done),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_data_oe(b_data_oe),
    .sram_rdata(b_sram_rdata),
    .Mem_CE(b_ce), .Mem_UB(b_ub), .Mem_LB(b_lb), .Mem_OE(b_oe), .Mem_WE(b_we),
    .busy(b_busy), .owner(b_owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_owner", {31'b0, owner}, 0);
    check("rst_strobes", {26'b0, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_data_oe}, 32'h3E);
    check("rst_addr", {12'b0, sram_addr}, 0);
    check("rst_wdata", {16'b0, sram_wdata}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_done", {30'b0, cpu_done, dma_done}, 0);
    @(negedge Clk) Reset_n = 1'b1;
    tick();
    // CPU read of 0x00123
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
    tick();
    check("rd_a1_oe", {29'b0, Mem_CE, Mem_OE, Mem_WE}, 32'h1);
    check("rd_a1_busy", {31'b0, busy}, 1);
    check("rd_a1_addr", {12'b0, sram_addr}, 32'h00123);
    check("rd_a1_doe", {31'b0, sram_data_oe}, 0);
    tick();
    check("rd_a2_oe", {29'b0, Mem_CE, Mem_OE, Mem_WE}, 32'h1);
    check("rd_a2_done", {30'b0, cpu_done, dma_done}, 0);
    tick();
    check("rd_done", {30'b0, cpu_done, dma_done}, 32'h2);
    check("rd_cpu_rdata", {16'b0, cpu_rdata}, 32'hBEEF);
    check("rd_dma_rdata", {16'b0, dma_rdata}, 0);
    check("rd_done_strobes", {26'b0, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_data_oe}, 32'h3E);
    cpu_req = 0;
    tick();
    check("rd_idle", {30'b0, busy, cpu_done}, 0);
    check("rd_hold", {16'b0, cpu_rdata}, 32'hBEEF);
    // DMA write of 0x1234 to 0x0ABCD
    dma_req = 1; dma_we = 1; dma_addr = 20'h0ABCD; dma_wdata = 16'h1234;
    tick();
    check("wr_a1", {28'b0, Mem_CE, Mem_OE, Mem_WE, sram_data_oe}, 32'h5);
    check("wr_a1_owner", {31'b0, owner}, 1);
    check("wr_a1_wdata", {16'b0, sram_wdata}, 32'h1234);
    tick();
    check("wr_a2", {28'b0, Mem_CE, Mem_OE, Mem_WE, sram_data_oe}, 32'h5);
    tick();
    check("wr_done_pins", {28'b0, Mem_CE, Mem_OE, Mem_WE, sram_data_oe}, 32'hE);
    check("wr_done", {30'b0, cpu_done, dma_done}, 32'h1);
    check("wr_cpu_rdata", {16'b0, cpu_rdata}, 32'hBEEF);
    dma_req = 0;
    tick();
    check("wr_idle_done", {30'b0, cpu_done, dma_done}, 0);
    check("wr_mem_addr", {12'b0, wr_addr}, 32'h0ABCD);
    check("wr_mem_data", {16'b0, wr_data}, 32'h1234);
    check("wr_we_cycles", wr_cnt, 2);
    // ties after reset alternate CPU, DMA, CPU, DMA with 4-cycle spacing
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    dma_req = 1; dma_we = 0; dma_addr = 20'h00020;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("tie_owner", {31'b0, owner}, n % 2);
      tick();
      tick();
      check("tie_done", {30'b0, cpu_done, dma_done}, (n % 2) ? 32'h1 : 32'h2);
      tick();
      check("tie_gap_idle", {29'b0, busy, cpu_done, dma_done}, 0);
    end
    cpu_req = 0; dma_req = 0;
    check("tie_cpu_rdata", {16'b0, cpu_rdata}, 32'h1111);
    check("tie_dma_rdata", {16'b0, dma_rdata}, 32'h2222);
    tick();
    check("tie_quiet", {31'b0, busy}, 0);
    // CPU changes its inputs mid-access
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00030; cpu_wdata = 16'h5555;
    tick();
    cpu_we = 0; cpu_addr = 20'h00040; cpu_wdata = 16'h9999;
    check("mid_a1_addr", {12'b0, sram_addr}, 32'h00030);
    check("mid_a1_pins", {28'b0, Mem_CE, Mem_OE, Mem_WE, sram_data_oe}, 32'h5);
    tick();
    check("mid_a2_addr", {12'b0, sram_addr}, 32'h00030);
    check("mid_a2_pins", {28'b0, Mem_CE, Mem_OE, Mem_WE, sram_data_oe}, 32'h5);
    tick();
    check("mid_done", {30'b0, cpu_done, dma_done}, 32'h2);
    cpu_req = 0;
    tick();
    check("mid_mem", {wr_addr[15:0], wr_data}, 32'h0030_5555);
    // reset in the second ACCESS cycle of a DMA write
    dma_req = 1; dma_we = 1; dma_addr = 20'h00050; dma_wdata = 16'h7777;
    tick();
    tick();
    check("ar_pre_we", {31'b0, Mem_WE}, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_async_pins", {26'b0, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, sram_data_oe}, 32'h3E);
    check("ar_async_state", {30'b0, busy, owner}, 0);
    check("ar_async_addr", {12'b0, sram_addr}, 0);
    dma_req = 0;
    tick();
    check("ar_no_done", {30'b0, cpu_done, dma_done}, 0);
    @(negedge Clk) Reset_n = 1'b1;
    tick();
    check("ar_idle", {29'b0, busy, cpu_done, dma_done}, 0);
    tick();
    check("ar_idle2", {29'b0, busy, cpu_done, dma_done}, 0);
    // single-cycle access build
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 20'h00001;
    tick();
    check("ac1_access", {29'b0, b_busy, b_oe, b_ce}, 32'h4);
    check("ac1_addr", {12'b0, b_sram_addr}, 32'h00001);
    tick();
    check("ac1_done", {30'b0, b_cpu_done, b_dma_done}, 32'h2);
    check("ac1_rdata", {b_cpu_rdata, b_dma_rdata}, 32'hCAFE_0000);
    check("ac1_pins", {27'b0, b_ce, b_ub, b_lb, b_we, b_data_oe}, 32'h1E);
    b_cpu_req = 0;
    tick();
    check("ac1_idle", {30'b0, b_busy, b_cpu_done}, 0);
    check("ac1_owner", {31'b0, b_owner}, 0);
    check("ac1_wdata", {b_sram_wdata, 16'b0}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single off-chip SRAM between the LC-3 CPU memory interface (driven by the instruction sequencer's MAR/MDR path) and a second requester, the DMA/program loader. Each requester issues word reads or writes with a req/done handshake. The block owns the SRAM control pins and sequences a fixed-length access: capture, drive, then turnaround. Arbitration between simultaneous requests is two-way round-robin.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access (≥1)

- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cpu_req / dma_req  in  1  access request; held high until matching done
- cpu_we / dma_we  in  1  1 = write, 0 = read; valid while req high
- cpu_addr / dma_addr  in  ADDR_W  word address
- cpu_wdata / dma_wdata  in  DATA_W  write data
- cpu_rdata / dma_rdata  out  DATA_W  registered read data, held until next read by that requester
- cpu_done / dma_done  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W  registered address to SRAM
- sram_wdata  out  DATA_W  registered write data
- sram_data_oe  out  1  1 = FPGA drives SRAM data bus (tristate enable)
- sram_rdata  in  DATA_W  SRAM data bus input
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1  active-low SRAM strobes
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = CPU, 1 = DMA; current or last grantee

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is high at the edge, pick a winner and latch its addr, we and wdata into sram_addr, sram_wdata and an internal we_q. Set owner, clear the cycle counter, go to ACCESS. With no request, stay in IDLE.
- Arbitration: a lone request always wins. On a tie, grant the requester that is not the last grantee. After reset the last grantee is DMA, so the CPU wins the first tie.
- ACCESS lasts exactly ACCESS_CYCLES cycles. Mem_CE = Mem_UB = Mem_LB = 0 throughout.
  - Read: Mem_OE = 0, Mem_WE = 1, sram_data_oe = 0. On the edge ending the last ACCESS cycle, capture sram_rdata into the owner's rdata register.
  - Write: Mem_OE = 1, Mem_WE = 0, sram_data_oe = 1.
- DONE: one cycle. Assert the owner's done. All strobes are inactive (CE, UB, LB, OE, WE = 1) and sram_data_oe = 0; this is the bus turnaround cycle. Next state is IDLE unconditionally.
- Requester inputs are ignored outside IDLE. The latched values govern the whole access.
- Strobes decode combinationally from state and we_q only, so they are glitch-free per state.
- The non-owner's rdata and done are untouched by an access.

## Timing
- Request sampled at edge k (state IDLE):
  - ACCESS spans cycles k+1 .. k+ACCESS_CYCLES.
  - done is high in cycle k+ACCESS_CYCLES+1.
  - rdata is valid in that same cycle.
- Access-to-access spacing is ACCESS_CYCLES+2 cycles. With the default, CPU req→done is 3 cycles after grant.
- A requester with registered logic sees done, then drops req in the following (IDLE) cycle, so there is no double grant. If req stays high in IDLE, a new access starts.
- Reset (asynchronous, any state including mid-ACCESS):
  - state = IDLE; busy = 0; owner = 0; last grantee = DMA.
  - sram_addr = 0, sram_wdata = 0, sram_data_oe = 0.
  - Mem_CE = Mem_UB = Mem_LB = Mem_OE = Mem_WE = 1.
  - cpu_rdata = dma_rdata = 0; cpu_done = dma_done = 0.
  - An interrupted access produces no done pulse.
- Counter width is $clog2(ACCESS_CYCLES+1). The counter does not wrap within an access.

## Structure
- Package sram_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}.
  - owner enum {OWN_CPU = 1'b0, OWN_DMA = 1'b1}.
  - Default ADDR_W and DATA_W constants.
- Sub-module rr_pick2: purely combinational. Inputs are req[1:0] and last; outputs are grant_valid and grant_id.
- The FSM, capture registers and strobe decode live in sram_port_arbiter.

## Test plan
- CPU read, addr 0x00123, SRAM model returns 0xBEEF: Mem_OE low for 2 cycles, cpu_done in cycle k+3, cpu_rdata = 0xBEEF, dma_rdata stays 0.
- DMA write, addr 0x0ABCD, data 0x1234: Mem_WE low for exactly 2 cycles, sram_data_oe high only in those cycles, model holds 0x1234 at 0x0ABCD, dma_done pulses once.
- Both request at the same edge after reset: CPU granted first and DMA second. Repeated ties alternate CPU, DMA, CPU, DMA. Gap between done pulses is 4 cycles.
- CPU changes cpu_addr and cpu_we mid-ACCESS: sram_addr and the strobes are unchanged and the original access completes.
- Reset_n asserted in the 2nd ACCESS cycle of a write: Mem_WE goes high in the same cycle without waiting for a clock edge, no done pulse, and state is IDLE after release.
- ACCESS_CYCLES = 1 build: read completes with done in cycle k+2 and data captured correctly.
